// File: rtl/uart_cmd_link.sv
// ---------------------------------------------------------------------------
// uart_cmd_link
//   Host-side 8N1 UART link for the command processor.
//   RX: two received bytes (high, then low) form a 16-bit command, held
//       with cmd_rdy until the processor clears it.
//   TX: one response byte per send_resp request; resp_sent pulses in the
//       last stop-bit cycle.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   RX           serial input from host (asynchronous to clk)
//   TX           serial output to host (registered)
//   cmd[15:0]    assembled command {first byte, second byte}
//   cmd_rdy      command valid, held until clr_cmd_rdy
//   clr_cmd_rdy  processor done with cmd
//   resp[7:0]    response byte, valid the cycle after send_resp
//   send_resp    request transmission of resp
//   resp_sent    one-cycle pulse when the TX stop bit completes
// ---------------------------------------------------------------------------
module uart_cmd_link #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int unsigned      CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]    HALF_CNT  = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0]    BIT_LAST  = CW'(BAUD_DIV - 1);
    // Stop state is one cycle short: the final stop-bit cycle is spent in
    // IDLE with resp_sent high, so a new request can be accepted there.
    localparam logic [CW-1:0]    STOP_LAST = CW'(BAUD_DIV - 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {WAIT_H, WAIT_L, FULL}                cmd_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    // RX synchronizer and edge history
    logic rx_s1_q, rx_s2_q, rx_prev_q;

    // RX receiver
    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q,   rx_cnt_d;
    logic [2:0]        rx_bit_q,   rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_rdy_q,   rx_rdy_d;

    // Command assembly
    cmd_state_e        cmd_state_q, cmd_state_d;
    logic [15:0]       cmd_q,       cmd_d;
    logic              cmd_rdy_q,   cmd_rdy_d;

    // TX transmitter
    tx_state_e         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q,   tx_cnt_d;
    logic [2:0]        tx_bit_q,   tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_q,       tx_d;
    logic              resp_sent_q, resp_sent_d;

    // ------------------------------------------------------------------
    // RX receiver: start on synchronized falling edge, mid-bit sampling
    // ------------------------------------------------------------------
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_rdy_d   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_CNT;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;        // glitch, not a start bit
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_LAST;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_LAST;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RX_IDLE;
                    rx_rdy_d   = rx_s2_q;            // framing error drops byte
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command assembly
    // ------------------------------------------------------------------
    always_comb begin
        cmd_state_d = cmd_state_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        unique case (cmd_state_q)
            WAIT_H: begin
                if (rx_rdy_q) begin
                    cmd_d[15:8] = rx_shift_q;
                    cmd_state_d = WAIT_L;
                end
            end
            WAIT_L: begin
                if (clr_cmd_rdy) begin
                    cmd_state_d = WAIT_H;            // resync, drop partial
                end else if (rx_rdy_q) begin
                    cmd_d[7:0]  = rx_shift_q;
                    cmd_rdy_d   = 1'b1;
                    cmd_state_d = FULL;
                end
            end
            FULL: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d   = 1'b0;
                    cmd_state_d = WAIT_H;
                end
            end
            default: cmd_state_d = WAIT_H;
        endcase
    end

    // ------------------------------------------------------------------
    // TX transmitter
    // ------------------------------------------------------------------
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        resp_sent_d = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (send_resp) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = BIT_LAST;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                // resp arrives one cycle after send_resp: capture it in the
                // first start-bit cycle.
                if (tx_cnt_q == BIT_LAST) begin
                    tx_shift_d = resp;
                end
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = BIT_LAST;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BIT_LAST;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_cnt_d   = STOP_LAST;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d  = TX_IDLE;
                    resp_sent_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_rdy_q    <= 1'b0;
            cmd_state_q <= WAIT_H;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            rx_s1_q     <= RX;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_rdy_q    <= rx_rdy_d;
            cmd_state_q <= cmd_state_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_link.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_link
//   Self-checking bench for uart_cmd_link at BAUD_DIV=16. Expected commands
//   and response bytes are queued when stimulus is driven and popped when
//   the DUT produces them.
// ---------------------------------------------------------------------------
module tb_uart_cmd_link;

    localparam int unsigned BD = 16;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    int n_cmp;
    int n_err;

    logic [15:0] cmd_sb[$];
    logic [7:0]  tx_sb[$];

    uart_cmd_link #(.BAUD_DIV(BD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame on RX followed by a short idle gap.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (BD) tick();
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) tick();
        end
        RX = stop;
        repeat (BD) tick();
        RX = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    // Called in the cycle the request is issued (cycle N); returns in the
    // resp_sent cycle N+10*BD. Checks TX and resp_sent every cycle.
    task automatic run_tx_frame(input logic [7:0] b, input bit poke_mid);
        logic [7:0] expb;
        logic       exp_tx;
        int         idx;
        send_resp = 1'b1;
        resp      = ~b;
        tx_sb.push_back(b);
        tick();
        send_resp = 1'b0;
        resp      = b;
        expb      = tx_sb.pop_front();
        for (int i = 1; i <= 10 * BD; i++) begin
            if (i == 2) resp = ~b;
            if (poke_mid && i == 50) begin
                send_resp = 1'b1;
                resp      = 8'hFF;
            end
            if (poke_mid && i == 51) begin
                send_resp = 1'b0;
                resp      = ~b;
            end
            idx = (i - 1) / BD;
            if (idx == 0)      exp_tx = 1'b0;
            else if (idx == 9) exp_tx = 1'b1;
            else               exp_tx = expb[idx-1];
            n_cmp++;
            if (TX !== exp_tx) begin
                n_err++;
                $display("FAIL tx_bit byte=%02h cycle=%0d TX=%b expected=%b", expb, i, TX, exp_tx);
            end
            n_cmp++;
            if (resp_sent !== (i == 10 * BD)) begin
                n_err++;
                $display("FAIL resp_sent byte=%02h cycle=%0d got=%b expected=%b", expb, i, resp_sent, (i == 10 * BD));
            end
            if (i < 10 * BD) tick();
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (TX !== 1'b1) begin n_err++; $display("FAIL reset_tx got=%b expected=1", TX); end
        n_cmp++;
        if (cmd !== 16'h0000) begin n_err++; $display("FAIL reset_cmd got=%04h expected=0000", cmd); end
        n_cmp++;
        if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL reset_cmd_rdy got=%b expected=0", cmd_rdy); end
        n_cmp++;
        if (resp_sent !== 1'b0) begin n_err++; $display("FAIL reset_resp_sent got=%b expected=0", resp_sent); end
    endtask

    task automatic test_cmd_full_drop();
        logic [15:0] exp;
        int          w;
        // first command
        cmd_sb.push_back(16'h4107);
        send_byte(8'h41, 1'b1);
        n_cmp++;
        if (cmd_rdy !== 1'b0 || cmd[15:8] !== 8'h41) begin
            n_err++;
            $display("FAIL high_byte cmd=%04h cmd_rdy=%b expected hi=41 rdy=0", cmd, cmd_rdy);
        end
        send_byte(8'h07, 1'b1);
        w = 0;
        while (cmd_rdy !== 1'b1 && w < 40) begin tick(); w++; end
        exp = cmd_sb.pop_front();
        n_cmp++;
        if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL cmd_rdy_timeout got=%b expected=1", cmd_rdy); end
        n_cmp++;
        if (cmd !== exp) begin n_err++; $display("FAIL cmd_value got=%04h expected=%04h", cmd, exp); end
        repeat (20) tick();
        n_cmp++;
        if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL cmd_rdy_hold got=%b expected=1", cmd_rdy); end
        // byte received while FULL is dropped
        send_byte(8'h99, 1'b1);
        n_cmp++;
        if (cmd !== 16'h4107 || cmd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL full_drop cmd=%04h rdy=%b expected 4107/1", cmd, cmd_rdy);
        end
        pulse_clr();
        n_cmp++;
        if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL clr_drop got=%b expected=0", cmd_rdy); end
        n_cmp++;
        if (cmd !== 16'h4107) begin n_err++; $display("FAIL clr_keep_cmd got=%04h expected=4107", cmd); end
        // clear in WAIT_H is ignored; following command still assembles
        pulse_clr();
        cmd_sb.push_back(16'h0005);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        w = 0;
        while (cmd_rdy !== 1'b1 && w < 40) begin tick(); w++; end
        exp = cmd_sb.pop_front();
        n_cmp++;
        if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL cmd2_timeout got=%b expected=1", cmd_rdy); end
        n_cmp++;
        if (cmd !== exp) begin n_err++; $display("FAIL cmd2_value got=%04h expected=%04h", cmd, exp); end
        pulse_clr();
    endtask

    task automatic test_glitch_framing();
        logic [15:0] exp;
        int          w;
        // 3-cycle low glitch
        RX = 1'b0;
        repeat (3) tick();
        RX = 1'b1;
        repeat (10 * BD + 10) tick();
        n_cmp++;
        if (cmd !== 16'h0005 || cmd_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL glitch cmd=%04h rdy=%b expected 0005/0", cmd, cmd_rdy);
        end
        // framing error
        send_byte(8'h3C, 1'b0);
        repeat (10) tick();
        n_cmp++;
        if (cmd !== 16'h0005 || cmd_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL framing cmd=%04h rdy=%b expected 0005/0", cmd, cmd_rdy);
        end
        // still waiting for a high byte
        cmd_sb.push_back(16'h1234);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        w = 0;
        while (cmd_rdy !== 1'b1 && w < 40) begin tick(); w++; end
        exp = cmd_sb.pop_front();
        n_cmp++;
        if (cmd_rdy !== 1'b1 || cmd !== exp) begin
            n_err++;
            $display("FAIL after_framing cmd=%04h rdy=%b expected %04h/1", cmd, cmd_rdy, exp);
        end
        pulse_clr();
    endtask

    task automatic test_back_to_back();
        run_tx_frame(8'hA5, 1'b1);
        tick();
        n_cmp++;
        if (TX !== 1'b1 || resp_sent !== 1'b0) begin
            n_err++;
            $display("FAIL tx_not_queued TX=%b resp_sent=%b expected 1/0", TX, resp_sent);
        end
        run_tx_frame(8'h3C, 1'b0);
        // request in the resp_sent cycle itself
        run_tx_frame(8'h81, 1'b0);
        tick();
        n_cmp++;
        if (TX !== 1'b1 || resp_sent !== 1'b0) begin
            n_err++;
            $display("FAIL tx_idle_end TX=%b resp_sent=%b expected 1/0", TX, resp_sent);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        int          w;
        cmd_sb.push_back(16'hBEEF);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        w = 0;
        while (cmd_rdy !== 1'b1 && w < 40) begin tick(); w++; end
        exp = cmd_sb.pop_front();
        n_cmp++;
        if (cmd_rdy !== 1'b1 || cmd !== exp) begin
            n_err++;
            $display("FAIL pre_reset cmd=%04h rdy=%b expected %04h/1", cmd, cmd_rdy, exp);
        end
        // start a TX frame and an RX frame, then reset mid-way
        send_resp = 1'b1;
        resp      = 8'h00;
        tick();
        send_resp = 1'b0;
        RX        = 1'b0;
        repeat (40) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (TX !== 1'b1) begin n_err++; $display("FAIL mid_reset_tx got=%b expected=1", TX); end
        n_cmp++;
        if (cmd !== 16'h0000) begin n_err++; $display("FAIL mid_reset_cmd got=%04h expected=0000", cmd); end
        n_cmp++;
        if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL mid_reset_rdy got=%b expected=0", cmd_rdy); end
        RX = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (TX !== 1'b1 || resp_sent !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_tx cycle=%0d TX=%b resp_sent=%b expected 1/0", i, TX, resp_sent);
            end
        end
        cmd_sb.push_back(16'hC35A);
        send_byte(8'hC3, 1'b1);
        send_byte(8'h5A, 1'b1);
        w = 0;
        while (cmd_rdy !== 1'b1 && w < 40) begin tick(); w++; end
        exp = cmd_sb.pop_front();
        n_cmp++;
        if (cmd_rdy !== 1'b1 || cmd !== exp) begin
            n_err++;
            $display("FAIL post_reset_cmd cmd=%04h rdy=%b expected %04h/1", cmd, cmd_rdy, exp);
        end
        pulse_clr();
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp        = 8'h00;
        send_resp   = 1'b0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        repeat (5) tick();
        test_cmd_full_drop();
        test_glitch_framing();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
